// File: rtl/iot_mon_pkg.sv
// Shared types and width helpers for the multi-channel IoT occupancy monitor.
package iot_mon_pkg;

   typedef enum logic {
      NORMAL = 1'b0,
      ALARM  = 1'b1
   } alarm_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Signed net-change width: enough for +/-N_CH plus a sign bit.
   function automatic int delta_width(input int n_ch);
      return clog2(n_ch + 1) + 1;
   endfunction

endpackage

// File: rtl/iot_popcount.sv
// Combinational population count of an N-bit vector.
module iot_popcount
   import iot_mon_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]              in_bits,
   output logic [clog2(N+1)-1:0]     count
);

   localparam int CW = clog2(N + 1);

   always_comb begin
      count = '0;
      for (int i = 0; i < N; i++) begin
         count = count + CW'(in_bits[i]);
      end
   end

endmodule

// File: rtl/iot_monitor_multi.sv
// Aggregates per-channel connect/disconnect strobes into a saturating
// active-device count with peak tracking, sticky clamp flag and hysteresis alarm.
module iot_monitor_multi
   import iot_mon_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int WIDTH    = 8,
   parameter int ALARM_HI = 200,
   parameter int ALARM_LO = 180
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   change,
   input  logic [N_CH-1:0]   on_off,
   input  logic              clr_peak,
   output logic [WIDTH-1:0]  counter_out,
   output logic [WIDTH-1:0]  peak_out,
   output logic              alarm,
   output logic              sat_err
);

   localparam int CW = clog2(N_CH + 1);
   localparam int DW = delta_width(N_CH);
   localparam int SW = WIDTH + 2;
   localparam logic [WIDTH-1:0] HI_THR = WIDTH'(ALARM_HI);
   localparam logic [WIDTH-1:0] LO_THR = WIDTH'(ALARM_LO);

   logic [CW-1:0]           ups;
   logic [CW-1:0]           downs;
   logic signed [DW-1:0]    delta;
   logic signed [SW-1:0]    sum;
   logic signed [SW-1:0]    max_val;
   logic [WIDTH-1:0]        next_cnt;
   logic                    clamp;

   logic [WIDTH-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]        peak_q, peak_d;
   logic                    sat_q, sat_d;
   alarm_state_e            state_q, state_d;

   iot_popcount #(.N(N_CH)) u_pop_up (
      .in_bits (change & on_off),
      .count   (ups)
   );

   iot_popcount #(.N(N_CH)) u_pop_dn (
      .in_bits (change & ~on_off),
      .count   (downs)
   );

   always_comb begin
      delta   = $signed({1'b0, ups}) - $signed({1'b0, downs});
      max_val = $signed({2'b00, {WIDTH{1'b1}}});
      sum     = $signed({2'b00, cnt_q}) + SW'(delta);
      clamp   = 1'b0;
      // Saturate at both ends rather than wrapping; any clamp is remembered.
      if (sum < 0) begin
         next_cnt = '0;
         clamp    = 1'b1;
      end else if (sum > max_val) begin
         next_cnt = {WIDTH{1'b1}};
         clamp    = 1'b1;
      end else begin
         next_cnt = sum[WIDTH-1:0];
      end

      cnt_d = next_cnt;
      sat_d = sat_q | clamp;

      if (clr_peak) begin
         peak_d = next_cnt;
      end else begin
         peak_d = (next_cnt > peak_q) ? next_cnt : peak_q;
      end

      // Alarm tracks next_cnt so it changes on the same edge as the count.
      state_d = state_q;
      case (state_q)
         NORMAL:  if (next_cnt >= HI_THR) state_d = ALARM;
         ALARM:   if (next_cnt <= LO_THR) state_d = NORMAL;
         default: state_d = NORMAL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q   <= '0;
         peak_q  <= '0;
         sat_q   <= 1'b0;
         state_q <= NORMAL;
      end else begin
         cnt_q   <= cnt_d;
         peak_q  <= peak_d;
         sat_q   <= sat_d;
         state_q <= state_d;
      end
   end

   assign counter_out = cnt_q;
   assign peak_out    = peak_q;
   assign sat_err     = sat_q;
   assign alarm       = (state_q == ALARM);

endmodule

// File: doc/iot_monitor_multi.md
Name: iot_monitor_multi

Overview:
Parametrised successor to the single-channel active IoT device counter. It aggregates connect/disconnect events from N_CH device ports in one clock. It maintains a saturating active-device count, a peak (high-watermark) register, a sticky saturation-error flag and a hysteresis occupancy alarm. It sits between the device-port event sources and the status/telemetry block.

Parameters:
N_CH, 4, number of device event channels (1..16)
WIDTH, 8, width of active-device count and peak
ALARM_HI, 200, count at or above which alarm asserts; constraint ALARM_LO < ALARM_HI <= 2^WIDTH-1
ALARM_LO, 180, count at or below which alarm deasserts

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-low; 0 at a rising edge clears all state
change  input  N_CH  per-channel event strobe, 1 = event this cycle
on_off  input  N_CH  per-channel event direction, 1 = device on (+1), 0 = device off (-1); ignored where change=0
clr_peak  input  1  peak reload request, single-cycle
counter_out  output  WIDTH  registered active-device count
peak_out  output  WIDTH  registered maximum count since reset or last clr_peak
alarm  output  1  registered occupancy alarm
sat_err  output  1  sticky: a clamp occurred since reset

Behaviour:
- Reset (rst=0 at edge): counter_out=0, peak_out=0, alarm=0, sat_err=0, FSM=NORMAL. Reset overrides every other input. Mid-operation reset clears everything on that edge. First event is counted on the first edge with rst=1.
- Per cycle, combinational:
  - ups = popcount(change & on_off)
  - downs = popcount(change & ~on_off)
  - delta = ups - downs, signed, width clog2(N_CH+1)+1
- sum = counter_out + delta, evaluated in WIDTH+2 signed bits. next_cnt clamps sum to [0, 2^WIDTH-1].
- Clamp: if sum < 0 or sum > 2^WIDTH-1, next_cnt takes the clamped bound and sat_err is set on the same edge. sat_err stays 1 until reset. There is no wrap-around, ever.
- Latency: 1 cycle. counter_out equals next_cnt after the edge on which the events were sampled.
- Simultaneous on/off events across channels net out in the same cycle. Example: 3 on + 1 off gives +2.
- Peak: if clr_peak=1, peak_out <= next_cnt; else peak_out <= max(peak_out, next_cnt). clr_peak wins over max.
- Alarm FSM, states NORMAL and ALARM, evaluated on next_cnt so alarm is aligned with counter_out:
  - NORMAL -> ALARM when next_cnt >= ALARM_HI
  - ALARM -> NORMAL when next_cnt <= ALARM_LO
  - otherwise hold the current state
  - alarm = (state == ALARM)
- No event (change=0): counter, peak, alarm and sat_err hold.

Decomposition:
- Shared package iot_mon_pkg:
  - alarm state enum (NORMAL, ALARM)
  - clog2 helper function
  - delta width derivation constant
- Sub-module iot_popcount:
  - parameter N; input N bits; output clog2(N+1) bits; purely combinational
  - instantiated twice, once for ups and once for downs
- Top level holds the clamp arithmetic, counter, peak, sat_err and FSM.

Test Plan:
Defaults: N_CH=4, WIDTH=8, ALARM_HI=200, ALARM_LO=180.
1. Reset priority: rst=0 for 2 cycles with change=4'hF, on_off=4'hF -> counter_out=0, peak_out=0, alarm=0, sat_err=0. Release rst -> next edge counter_out=4.
2. Simultaneous net: from 0, change=4'b1111, on_off=4'b0111 for one cycle -> counter_out=2. Then change=4'b0011, on_off=4'b0000 -> counter_out=0, sat_err=0.
3. Underflow clamp: counter_out=1, change=4'hF, on_off=4'h0 -> counter_out=0, sat_err=1. sat_err stays 1 after 5 idle cycles.
4. Overflow clamp: counter_out=254, change=4'hF, on_off=4'hF -> counter_out=255, sat_err=1, peak_out=255. Repeat -> holds 255.
5. Alarm hysteresis: ramp +1/cycle to 200 -> alarm=1 on the same edge counter_out=200. Decrement to 181 -> alarm=1. Reach 180 -> alarm=0. Climb to 199 -> alarm=0.
6. Peak and reset mid-op: climb to 10, decrement to 5 -> peak_out=10. clr_peak=1 with one +1 event -> peak_out=6, counter_out=6. Assert rst=0 during activity -> all outputs 0 on that edge.
